// File: rtl/mc_controller_pkg.sv
// mc_pkg: state encoding, opcode and aluop constants shared by the multicycle controller.
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] ALUOP_ADD = 6'b100000;
    localparam logic [5:0] ALUOP_SUB = 6'b100010;
endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction/status inputs and datapath control outputs of the controller.
interface mc_controller_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 6
) ();
    logic [OP_W-1:0]    opcode;
    logic [OP_W-1:0]    funct;
    logic               zero;
    logic               mem_ready;
    logic               iord;
    logic               memwrite;
    logic               irwrite;
    logic               regdst;
    logic               memtoreg;
    logic               regwrite;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic               pc_en;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal_op;
    logic [3:0]         state_dbg;
    modport master (
        input  opcode, funct, zero, mem_ready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pc_en, aluop, illegal_op, state_dbg
    );
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, pc_en, aluop, illegal_op, state_dbg
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle main control FSM driving datapath enables and aluop.
// Optional bne support is enabled by defining MC_CONTROLLER_BNE_EN.
module mc_controller
    import mc_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    mc_controller_if.master  bus
);
    state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d        = FETCH;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.pc_en      = 1'b0;
        bus.aluop      = ALUOP_ADD;
        bus.illegal_op = 1'b0;
        bus.state_dbg  = state_q;
        case (state_q)
            FETCH: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.mem_ready;
                bus.pc_en   = bus.mem_ready;
                state_d     = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BEQ, OP_BNE: state_d = BRANCH;
`else
                    OP_BEQ:       state_d = BRANCH;
`endif
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      bus.illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.iord = 1'b1;
                state_d  = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                state_d      = bus.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                bus.alusrca = 1'b1;
                bus.aluop   = bus.funct;
                state_d     = ALUWB;
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALUOP_SUB;
                bus.pcsrc   = 2'b01;
`ifdef MC_CONTROLLER_BNE_EN
                bus.pc_en   = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
                bus.pc_en   = bus.zero;
`endif
            end
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: bus.regwrite = 1'b1;
            JUMP: begin
                bus.pcsrc = 2'b10;
                bus.pc_en = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // Outputs are forced quiet for as long as reset is held, including aluop.
        if (!reset_n) begin
            bus.irwrite = 1'b0;
            bus.pc_en   = 1'b0;
            bus.alusrcb = 2'b00;
            bus.aluop   = '0;
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven instruction runs with a scoreboard of per-instruction summaries.
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mc_controller_if bus ();
    mc_controller dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        int         cyc;
        int         rw;
        int         mw;
        int         ill;
        int         pce;
        int         io;
        logic [1:0] wb;
        logic [5:0] xop;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         fw;
        int         mw;
        obs_t       e;
    } vec_t;

    obs_t sb[$];
    vec_t tbl[12];

    task automatic chk(input string n, input int a, input int e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int cyc, wf, wm;
        bit left;
        obs_t o, e;
        cyc = 0; wf = v.fw; wm = v.mw; left = 0;
        o = '{cyc: 0, rw: 0, mw: 0, ill: 0, pce: 0, io: 0, wb: 2'b00, xop: 6'd0};
        bus.opcode = v.op; bus.funct = v.fn; bus.zero = v.z;
        sb.push_back(v.e);
        while (cyc < 40 && !(left && bus.state_dbg == 4'd0)) begin
            if (bus.state_dbg == 4'd0) begin
                bus.mem_ready = (wf == 0);
                if (wf > 0) wf--;
            end else if (bus.state_dbg == 4'd3 || bus.state_dbg == 4'd5) begin
                bus.mem_ready = (wm == 0);
                if (wm > 0) wm--;
            end else bus.mem_ready = 1'b1;
            @(negedge clk);
            o.rw  += int'(bus.regwrite);
            o.mw  += int'(bus.memwrite);
            o.ill += int'(bus.illegal_op);
            o.pce += int'(bus.pc_en);
            o.io  += int'(bus.iord);
            if (bus.regwrite) o.wb = {bus.regdst, bus.memtoreg};
            if (bus.state_dbg == 4'd6 || bus.state_dbg == 4'd8) o.xop = bus.aluop;
            @(posedge clk); #1;
            cyc++;
            if (bus.state_dbg != 4'd0) left = 1;
        end
        o.cyc = cyc;
        chk($sformatf("v%0d.timeout", idx), int'(cyc < 40), 1);
        e = sb.pop_front();
        chk($sformatf("v%0d.cycles", idx), o.cyc, e.cyc);
        chk($sformatf("v%0d.regwrite", idx), o.rw, e.rw);
        chk($sformatf("v%0d.memwrite", idx), o.mw, e.mw);
        chk($sformatf("v%0d.illegal", idx), o.ill, e.ill);
        chk($sformatf("v%0d.pc_en", idx), o.pce, e.pce);
        chk($sformatf("v%0d.iord", idx), o.io, e.io);
        chk($sformatf("v%0d.wbsel", idx), int'(o.wb), int'(e.wb));
        chk($sformatf("v%0d.aluop", idx), int'(o.xop), int'(e.xop));
    endtask

    initial begin
        int n;
        //                op          fn          z     fw mw   cyc rw mw ill pce io wb     xop
        tbl[0]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, '{4, 1, 0, 0, 1, 0, 2'b10, 6'b100000}};
        tbl[1]  = '{6'b000000, 6'b100010, 1'b0, 1, 0, '{5, 1, 0, 0, 1, 0, 2'b10, 6'b100010}};
        tbl[2]  = '{6'b100011, 6'b000000, 1'b0, 0, 2, '{7, 1, 0, 0, 1, 3, 2'b01, 6'b000000}};
        tbl[3]  = '{6'b100011, 6'b000000, 1'b0, 0, 0, '{5, 1, 0, 0, 1, 1, 2'b01, 6'b000000}};
        tbl[4]  = '{6'b101011, 6'b000000, 1'b0, 0, 1, '{5, 0, 2, 0, 1, 2, 2'b00, 6'b000000}};
        tbl[5]  = '{6'b000100, 6'b000000, 1'b1, 0, 0, '{3, 0, 0, 0, 2, 0, 2'b00, 6'b100010}};
        tbl[6]  = '{6'b000100, 6'b000000, 1'b0, 0, 0, '{3, 0, 0, 0, 1, 0, 2'b00, 6'b100010}};
        tbl[7]  = '{6'b001000, 6'b000000, 1'b0, 0, 0, '{4, 1, 0, 0, 1, 0, 2'b00, 6'b000000}};
        tbl[8]  = '{6'b000010, 6'b000000, 1'b0, 0, 0, '{3, 0, 0, 0, 2, 0, 2'b00, 6'b000000}};
        tbl[9]  = '{6'b111111, 6'b000000, 1'b0, 0, 0, '{2, 0, 0, 1, 1, 0, 2'b00, 6'b000000}};
`ifdef MC_CONTROLLER_BNE_EN
        tbl[10] = '{6'b000101, 6'b000000, 1'b0, 0, 0, '{3, 0, 0, 0, 2, 0, 2'b00, 6'b100010}};
        tbl[11] = '{6'b000101, 6'b000000, 1'b1, 0, 0, '{3, 0, 0, 0, 1, 0, 2'b00, 6'b100010}};
`else
        tbl[10] = '{6'b000101, 6'b000000, 1'b0, 0, 0, '{2, 0, 0, 1, 1, 0, 2'b00, 6'b000000}};
        tbl[11] = '{6'b000101, 6'b000000, 1'b1, 0, 0, '{2, 0, 0, 1, 1, 0, 2'b00, 6'b000000}};
`endif
        bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.irwrite", int'(bus.irwrite), 0);
        chk("rst.pc_en", int'(bus.pc_en), 0);
        chk("rst.aluop", int'(bus.aluop), 0);
        chk("rst.state", int'(bus.state_dbg), 0);
        reset_n = 1'b1;
        #1;
        chk("rel.aluop", int'(bus.aluop), 32);
        chk("rel.irwrite", int'(bus.irwrite), 1);
        chk("rel.pc_en", int'(bus.pc_en), 1);
        chk("rel.alusrcb", int'(bus.alusrcb), 1);
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("rel.hold", int'(bus.state_dbg), 0);
        foreach (tbl[i]) run(i, tbl[i]);
        bus.opcode = 6'b101011; bus.zero = 1'b0;
        n = 0;
        while (bus.state_dbg != 4'd5 && n < 10) begin
            bus.mem_ready = (bus.state_dbg == 4'd0);
            @(posedge clk); #1;
            n++;
        end
        bus.mem_ready = 1'b0;
        chk("mw.reach", int'(bus.state_dbg), 5);
        @(negedge clk);
        chk("mw.memwrite", int'(bus.memwrite), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mwrst.memwrite", int'(bus.memwrite), 0);
        chk("mwrst.iord", int'(bus.iord), 0);
        chk("mwrst.state", int'(bus.state_dbg), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("mwrel.state", int'(bus.state_dbg), 0);
        chk("mwrel.regwrite", int'(bus.regwrite), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
